// File: rtl/fetch_queue.sv
// Instruction fetch queue: tracks one in-flight memory request and buffers
// returned {inst, pc} pairs for decode.
module fetch_queue #(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     req_valid,
  input  logic [31:0]              pc_in,
  output logic                     issue_ok,
  input  logic [31:0]              inst_in,
  input  logic                     flush,
  output logic                     deq_valid,
  input  logic                     deq_ready,
  output logic [31:0]              deq_inst,
  output logic [31:0]              deq_pc,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);

  logic [31:0]   mem_inst [DEPTH];
  logic [31:0]   mem_pc   [DEPTH];
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] wr_ptr;
  logic          inflight_q;
  logic [31:0]   pend_pc;
  logic [AW+1:0] credit_used;
  logic          accept;
  logic          fill;
  logic          deq;

  // The in-flight request reserves a slot, so overflow can never happen;
  // a same-cycle dequeue is deliberately not counted as freeing one.
  assign credit_used = {1'b0, count} + {{(AW+1){1'b0}}, inflight_q};
  assign issue_ok    = reset & ~flush & (credit_used < (AW+2)'(DEPTH));
  assign accept      = req_valid & issue_ok;
  assign fill        = inflight_q & ~flush;
  assign deq         = deq_valid & deq_ready & ~flush;

  assign deq_valid = (count != '0);
  assign deq_inst  = mem_inst[rd_ptr];
  assign deq_pc    = mem_pc[rd_ptr];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count      <= '0;
      rd_ptr     <= '0;
      wr_ptr     <= '0;
      inflight_q <= 1'b0;
      pend_pc    <= '0;
    end else if (flush) begin
      count      <= '0;
      rd_ptr     <= '0;
      wr_ptr     <= '0;
      inflight_q <= 1'b0;
    end else begin
      inflight_q <= accept;
      if (accept) pend_pc <= pc_in;
      if (fill)   wr_ptr  <= wr_ptr + 1'b1;
      if (deq)    rd_ptr  <= rd_ptr + 1'b1;
      if (fill && !deq)      count <= count + 1'b1;
      else if (!fill && deq) count <= count - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem_inst[i] <= '0;
        mem_pc[i]   <= '0;
      end
    end else if (fill) begin
      mem_inst[wr_ptr] <= inst_in;
      mem_pc[wr_ptr]   <= pend_pc;
    end
  end

endmodule

// File: tb/tb_fetch_queue.sv
// Self-checking bench for fetch_queue: vector table, directed corner sequences
// and randomized traffic compared against a queue-based reference model.
module tb_fetch_queue;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid;
  logic [31:0] pc_in;
  logic        issue_ok;
  logic [31:0] inst_in;
  logic        flush;
  logic        deq_valid;
  logic        deq_ready;
  logic [31:0] deq_inst;
  logic [31:0] deq_pc;
  logic [2:0]  count;

  fetch_queue #(.DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .pc_in(pc_in),
    .issue_ok(issue_ok), .inst_in(inst_in), .flush(flush),
    .deq_valid(deq_valid), .deq_ready(deq_ready), .deq_inst(deq_inst),
    .deq_pc(deq_pc), .count(count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] inst;
  } ent_t;

  typedef struct {
    logic        rv;
    logic [31:0] pc;
    logic        fl;
    logic        dr;
    logic        ok;
    logic [2:0]  cnt;
    logic        vld;
    logic [31:0] epc;
    logic [31:0] einst;
  } vec_t;

  ent_t        mq[$];
  bit          m_inflight;
  logic [31:0] m_pend;
  int          tests;
  int          fails;
  vec_t        vecs[14];

  // Memory returns pc+3 for every fetched address.
  function automatic logic [31:0] inst_for(input logic [31:0] pc);
    return pc + 32'h3;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic rv, input logic [31:0] pc, input logic fl, input logic dr);
    req_valid = rv;
    pc_in     = pc;
    flush     = fl;
    deq_ready = dr;
    inst_in   = m_inflight ? inst_for(m_pend) : $urandom;
  endtask

  task automatic check_model();
    int n;
    n = mq.size();
    chk("issue_ok", {31'b0, issue_ok}, {31'b0, (!flush && (n + int'(m_inflight) < DEPTH))});
    chk("count", {29'b0, count}, n);
    chk("deq_valid", {31'b0, deq_valid}, {31'b0, n != 0});
    if (n != 0) begin
      chk("deq_pc", deq_pc, mq[0].pc);
      chk("deq_inst", deq_inst, mq[0].inst);
    end
  endtask

  task automatic advance();
    bit ok;
    ok = !flush && (mq.size() + int'(m_inflight) < DEPTH);
    if (flush) begin
      mq.delete();
      m_inflight = 1'b0;
    end else begin
      if (deq_ready && mq.size() > 0) void'(mq.pop_front());
      if (m_inflight) mq.push_back('{pc: m_pend, inst: inst_in});
      m_inflight = req_valid && ok;
      if (req_valid && ok) m_pend = pc_in;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic cyc_begin(input logic rv, input logic [31:0] pc, input logic fl, input logic dr);
    drive(rv, pc, fl, dr);
    #4;
    check_model();
  endtask

  task automatic cycle(input logic rv, input logic [31:0] pc, input logic fl, input logic dr);
    cyc_begin(rv, pc, fl, dr);
    advance();
  endtask

  initial begin
    tests = 0;
    fails = 0;
    m_inflight = 1'b0;
    m_pend = '0;
    //            rv   pc      fl  dr   ok  cnt  vld  epc     einst
    vecs[0]  = '{1'b1, 32'h10, 1'b0, 1'b0, 1'b1, 3'd0, 1'b0, 32'h0,  32'h0};
    vecs[1]  = '{1'b0, 32'h0,  1'b0, 1'b0, 1'b1, 3'd0, 1'b0, 32'h0,  32'h0};
    vecs[2]  = '{1'b0, 32'h0,  1'b0, 1'b0, 1'b1, 3'd1, 1'b1, 32'h10, 32'h13};
    vecs[3]  = '{1'b0, 32'h0,  1'b0, 1'b1, 1'b1, 3'd1, 1'b1, 32'h10, 32'h13};
    vecs[4]  = '{1'b0, 32'h0,  1'b0, 1'b1, 1'b1, 3'd0, 1'b0, 32'h0,  32'h0};
    vecs[5]  = '{1'b1, 32'h0,  1'b0, 1'b0, 1'b1, 3'd0, 1'b0, 32'h0,  32'h0};
    vecs[6]  = '{1'b1, 32'h4,  1'b0, 1'b0, 1'b1, 3'd0, 1'b0, 32'h0,  32'h0};
    vecs[7]  = '{1'b1, 32'h8,  1'b0, 1'b0, 1'b1, 3'd1, 1'b1, 32'h0,  32'h3};
    vecs[8]  = '{1'b1, 32'hC,  1'b0, 1'b0, 1'b1, 3'd2, 1'b1, 32'h0,  32'h3};
    vecs[9]  = '{1'b1, 32'h10, 1'b0, 1'b0, 1'b0, 3'd3, 1'b1, 32'h0,  32'h3};
    vecs[10] = '{1'b0, 32'h0,  1'b0, 1'b0, 1'b0, 3'd4, 1'b1, 32'h0,  32'h3};
    vecs[11] = '{1'b0, 32'h0,  1'b0, 1'b0, 1'b0, 3'd4, 1'b1, 32'h0,  32'h3};
    vecs[12] = '{1'b0, 32'h0,  1'b1, 1'b0, 1'b0, 3'd4, 1'b1, 32'h0,  32'h3};
    vecs[13] = '{1'b0, 32'h0,  1'b0, 1'b0, 1'b1, 3'd0, 1'b0, 32'h0,  32'h0};

    reset = 1'b0;
    drive(1'b1, 32'h0, 1'b0, 1'b1);
    repeat (2) @(posedge clk);
    #2;
    chk("rst_count", {29'b0, count}, 32'd0);
    chk("rst_deq_valid", {31'b0, deq_valid}, 32'd0);
    chk("rst_issue_ok", {31'b0, issue_ok}, 32'd0);
    chk("rst_deq_pc", deq_pc, 32'd0);
    chk("rst_deq_inst", deq_inst, 32'd0);
    @(negedge clk);
    reset = 1'b1;

    for (int i = 0; i < 14; i++) begin
      drive(vecs[i].rv, vecs[i].pc, vecs[i].fl, vecs[i].dr);
      #4;
      chk($sformatf("vec%0d_issue_ok", i), {31'b0, issue_ok}, {31'b0, vecs[i].ok});
      chk($sformatf("vec%0d_count", i), {29'b0, count}, {29'b0, vecs[i].cnt});
      chk($sformatf("vec%0d_deq_valid", i), {31'b0, deq_valid}, {31'b0, vecs[i].vld});
      if (vecs[i].vld) begin
        chk($sformatf("vec%0d_deq_pc", i), deq_pc, vecs[i].epc);
        chk($sformatf("vec%0d_deq_inst", i), deq_inst, vecs[i].einst);
      end
      check_model();
      advance();
    end

    // Flush while a request is in flight: its word must never appear.
    cycle(1'b1, 32'h20, 1'b0, 1'b0);
    cycle(1'b1, 32'h24, 1'b0, 1'b0);
    cycle(1'b0, 32'h0, 1'b0, 1'b0);
    cycle(1'b1, 32'h40, 1'b0, 1'b0);
    cyc_begin(1'b1, 32'h44, 1'b1, 1'b1);
    chk("flush_pre_count", {29'b0, count}, 32'd2);
    advance();
    cyc_begin(1'b1, 32'h200, 1'b0, 1'b0);
    chk("flush_post_count", {29'b0, count}, 32'd0);
    chk("flush_post_valid", {31'b0, deq_valid}, 32'd0);
    chk("flush_post_issue_ok", {31'b0, issue_ok}, 32'd1);
    advance();
    cycle(1'b0, 32'h0, 1'b0, 1'b0);
    cyc_begin(1'b0, 32'h0, 1'b0, 1'b1);
    chk("flush_redirect_pc", deq_pc, 32'h200);
    chk("flush_redirect_inst", deq_inst, 32'h203);
    advance();

    // Streaming: one dequeue per cycle once the pipe fills, wrapping pointers.
    for (int i = 0; i < 12; i++) begin
      cyc_begin(1'b1, 32'h100 + 32'(4 * i), 1'b0, 1'b1);
      if (i >= 2) begin
        chk("stream_count", {29'b0, count}, 32'd1);
        chk("stream_pc", deq_pc, 32'h100 + 32'(4 * (i - 2)));
      end
      advance();
    end
    repeat (3) cycle(1'b0, 32'h0, 1'b0, 1'b1);

    // Asynchronous reset between edges with count=3 and a request in flight.
    cycle(1'b1, 32'h300, 1'b0, 1'b0);
    cycle(1'b1, 32'h304, 1'b0, 1'b0);
    cycle(1'b1, 32'h308, 1'b0, 1'b0);
    cycle(1'b1, 32'h30C, 1'b0, 1'b0);
    drive(1'b0, 32'h0, 1'b0, 1'b0);
    #2;
    chk("pre_areset_count", {29'b0, count}, 32'd3);
    reset = 1'b0;
    #1;
    chk("areset_count", {29'b0, count}, 32'd0);
    chk("areset_deq_valid", {31'b0, deq_valid}, 32'd0);
    chk("areset_issue_ok", {31'b0, issue_ok}, 32'd0);
    chk("areset_deq_pc", deq_pc, 32'd0);
    chk("areset_deq_inst", deq_inst, 32'd0);
    @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    mq.delete();
    m_inflight = 1'b0;
    cycle(1'b1, 32'h400, 1'b0, 1'b0);
    cycle(1'b0, 32'h0, 1'b0, 1'b0);
    cycle(1'b0, 32'h0, 1'b0, 1'b1);
    cycle(1'b0, 32'h0, 1'b0, 1'b1);

    for (int i = 0; i < 400; i++) begin
      cycle(($urandom % 4) != 0, $urandom & 32'hFFFF_FFFC,
            ($urandom % 25) == 0, ($urandom % 3) != 0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/fetch_queue.md
FETCH_QUEUE -- requirements
Module: fetch_queue

Interface
REQ-001 Parameter DEPTH, default 4, queue entries; SHALL be a power of two, 2..16.
REQ-002 clk  in  1  sole clock; all state SHALL update on its rising edge.
REQ-003 reset  in  1  reset, asynchronous, active-low (0 = reset asserted).
REQ-004 req_valid  in  1  fetch request issued to instruction memory this cycle.
REQ-005 pc_in  in  32  byte address of the request; sampled only when a request is accepted.
REQ-006 issue_ok  out  1  combinational; a request SHALL be accepted only when req_valid=1 and issue_ok=1.
REQ-007 inst_in  in  32  instruction word from memory, valid exactly one cycle after an accepted request.
REQ-008 flush  in  1  discard all queued and in-flight instructions (branch redirect).
REQ-009 deq_valid  out  1  head entry present.
REQ-010 deq_ready  in  1  decode consumes head when deq_valid=1.
REQ-011 deq_inst  out  32  head instruction word.
REQ-012 deq_pc  out  32  byte address of head instruction.
REQ-013 count  out  log2(DEPTH)+1  number of occupied entries.

Function
REQ-014 Storage: DEPTH entries of {inst[31:0], pc[31:0]}; read pointer rd_ptr and write pointer wr_ptr, each log2(DEPTH) bits, SHALL wrap modulo DEPTH.
REQ-015 In-flight tracking: an accepted request SHALL set inflight_q=1 and latch pc_in into pend_pc; otherwise inflight_q SHALL clear next edge.
REQ-016 Fill: when inflight_q=1 and flush=0, {inst_in, pend_pc} SHALL be written at wr_ptr at that edge and wr_ptr incremented.
REQ-017 Latency: request accepted at edge-cycle t -> entry visible on deq_* with deq_valid=1 in cycle t+2.
REQ-018 Credit: issue_ok SHALL equal (flush=0) and (count + inflight_q < DEPTH); a same-cycle dequeue SHALL NOT be credited.
REQ-019 Overflow SHALL be impossible by REQ-018; a fill SHALL never occur with count=DEPTH.
REQ-020 deq_valid SHALL equal (count != 0); deq_inst/deq_pc SHALL be the entry at rd_ptr, combinationally.
REQ-021 Dequeue: deq_valid=1 and deq_ready=1 SHALL increment rd_ptr; deq_ready with count=0 SHALL have no effect.
REQ-022 Simultaneous fill and dequeue SHALL leave count unchanged and advance both pointers.
REQ-023 Pending fill with count=0 SHALL NOT bypass to deq_*; the word appears the following cycle.
REQ-024 Flush: at the edge with flush=1, count, rd_ptr, wr_ptr, inflight_q SHALL become 0; any inst_in arriving that cycle and any dequeue that cycle SHALL be discarded; req_valid that cycle SHALL be ignored.
REQ-025 Post-flush: a request in the cycle after flush SHALL be accepted normally (issue_ok=1).
REQ-026 deq_inst/deq_pc contents when deq_valid=0 are don't-care but SHALL NOT be X after reset.

Reset
REQ-027 reset=0 SHALL immediately (asynchronously) force count=0, rd_ptr=0, wr_ptr=0, inflight_q=0, pend_pc=0 and all storage to 0.
REQ-028 During reset: deq_valid=0, deq_inst=0, deq_pc=0, issue_ok=0.
REQ-029 Reset asserted mid-flight SHALL drop the in-flight response; first edge after release SHALL accept a request.

Verification
REQ-030 Single fetch: reset release, req_valid=1 pc_in=0x0000_0010, next cycle inst_in=0x0000_0013 -> cycle t+2 deq_valid=1 deq_pc=0x10 deq_inst=0x13, count=1.
REQ-031 Fill to full: DEPTH=4, deq_ready=0, 5 back-to-back requests at pc 0,4,8,12,16 -> first 4 accepted, issue_ok=0 from 4th accept onward, count settles at 4, head pc=0.
REQ-032 Streaming: deq_ready=1 held, requests every cycle pc 0x100 step 4 -> after 2-cycle latency one dequeue per cycle, pcs in order, count stays 1, no loss.
REQ-033 Flush with in-flight: count=2, request accepted at pc 0x40, flush=1 next cycle together with inst_in -> count=0, deq_valid=0, 0x40 word never dequeued; request pc 0x200 following cycle delivered 2 cycles later.
REQ-034 Wrap-around: 10 enqueues/dequeues with DEPTH=4 -> pointers wrap, all 10 pcs dequeued in order with matching instructions.
REQ-035 Async reset: reset=0 asserted between edges with count=3 -> deq_valid=0 and count=0 before next edge.
